miriscv_apb_bridge: RTL and testbench

MIRISCV_APB_BRIDGE -- requirements
Module: miriscv_apb_bridge

---
 rtl/miriscv_apb_bridge_if.sv | 39 +++
 rtl/miriscv_apb_bridge.sv | 139 +++++++++++++
 tb/tb_miriscv_apb_bridge.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/miriscv_apb_bridge_if.sv
// Signal bundle between the core data port, the bridge and the APB slaves.
// The bridge uses the master modport; the core/slave side uses the slave modport.
interface miriscv_apb_bridge_if #(
    parameter int XLEN = 32,
    parameter int NSLV = 2
);
    logic                   data_req_i;
    logic                   data_we_i;
    logic [XLEN/8-1:0]      data_be_i;
    logic [XLEN-1:0]        data_addr_i;
    logic [XLEN-1:0]        data_wdata_i;
    logic                   data_rvalid_o;
    logic [XLEN-1:0]        data_rdata_o;
    logic                   data_err_o;

    logic [NSLV-1:0]        psel_o;
    logic                   penable_o;
    logic                   pwrite_o;
    logic [XLEN-1:0]        paddr_o;
    logic [XLEN-1:0]        pwdata_o;
    logic [XLEN/8-1:0]      pstrb_o;
    logic [NSLV*XLEN-1:0]   prdata_i;
    logic [NSLV-1:0]        pready_i;
    logic [NSLV-1:0]        pslverr_i;

    modport master (
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_rvalid_o, data_rdata_o, data_err_o,
        output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o,
        input  prdata_i, pready_i, pslverr_i
    );

    modport slave (
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_rvalid_o, data_rdata_o, data_err_o,
        input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o,
        output prdata_i, pready_i, pslverr_i
    );
endinterface

// File: rtl/miriscv_apb_bridge.sv
// Core data port to APB4 bridge: one transfer at a time, address-decoded slave
// select, per-transfer wait-state timeout, one-cycle completion pulse.
module miriscv_apb_bridge #(
    parameter int XLEN    = 32,
    parameter int NSLV    = 2,
    parameter int SEL_LSB = 12,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    miriscv_apb_bridge_if.master  bus
);
    localparam int              IDXW         = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int              BEW          = XLEN / 8;
    localparam logic [XLEN-1:0] TIMEOUT_DATA = XLEN'(32'hDEAD_BEEF);
    localparam logic [15:0]     TIMEOUT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t            state;
    state_t            state_next;

    logic [IDXW-1:0]   req_idx;
    logic [IDXW-1:0]   idx;
    logic              decode_err;
    logic              accept;
    logic              sel_ready;
    logic              sel_err;
    logic [XLEN-1:0]   sel_rdata;
    logic              timed_out;
    logic [15:0]       wait_cnt;

    logic [XLEN-1:0]   paddr;
    logic [XLEN-1:0]   pwdata;
    logic [BEW-1:0]    pstrb;
    logic              pwrite;
    logic [XLEN-1:0]   rdata;
    logic              err;

    generate
        if (NSLV == 1) begin : g_single
            assign req_idx = '0;
        end else begin : g_multi
            assign req_idx = bus.data_addr_i[SEL_LSB +: IDXW];
        end
    endgenerate

    // Index field can encode more slaves than exist when NSLV is not a power of two.
    assign decode_err = {1'b0, req_idx} >= (IDXW + 1)'(NSLV);
    assign accept     = bus.data_req_i && ((state == IDLE) || (state == RESP));
    assign sel_ready  = bus.pready_i[idx];
    assign sel_err    = bus.pslverr_i[idx];
    assign sel_rdata  = bus.prdata_i[int'(idx) * XLEN +: XLEN];
    assign timed_out  = (wait_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, RESP: begin
                if (bus.data_req_i) begin
                    state_next = decode_err ? RESP : SETUP;
                end else begin
                    state_next = IDLE;
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                if (sel_ready || timed_out) begin
                    state_next = RESP;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request capture, wait counter and response registers; the response holds until the next RESP.
    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            idx      <= '0;
            paddr    <= '0;
            pwdata   <= '0;
            pstrb    <= '0;
            pwrite   <= 1'b0;
            wait_cnt <= '0;
            rdata    <= '0;
            err      <= 1'b0;
        end else begin
            if (accept) begin
                idx    <= req_idx;
                paddr  <= bus.data_addr_i;
                pwdata <= bus.data_wdata_i;
                pstrb  <= bus.data_we_i ? bus.data_be_i : '0;
                pwrite <= bus.data_we_i;
                if (decode_err) begin
                    rdata <= '0;
                    err   <= 1'b1;
                end
            end

            if (state == SETUP) begin
                wait_cnt <= '0;
            end else if ((state == ACCESS) && !sel_ready) begin
                wait_cnt <= wait_cnt + 16'd1;
            end

            if (state == ACCESS) begin
                if (sel_ready) begin
                    rdata <= pwrite ? '0 : sel_rdata;
                    err   <= sel_err;
                end else if (timed_out) begin
                    rdata <= TIMEOUT_DATA;
                    err   <= 1'b1;
                end
            end
        end
    end

    assign bus.psel_o        = ((state == SETUP) || (state == ACCESS)) ? (NSLV'(1) << idx) : '0;
    assign bus.penable_o     = (state == ACCESS);
    assign bus.pwrite_o      = pwrite;
    assign bus.paddr_o       = paddr;
    assign bus.pwdata_o      = pwdata;
    assign bus.pstrb_o       = pstrb;
    assign bus.data_rvalid_o = (state == RESP);
    assign bus.data_rdata_o  = rdata;
    assign bus.data_err_o    = err;
endmodule

// File: tb/tb_miriscv_apb_bridge.sv
// Scoreboard bench for miriscv_apb_bridge with three slaves and a short timeout so
// the decode-error and timeout paths are reachable.
module tb_miriscv_apb_bridge;
    localparam int XLEN    = 32;
    localparam int NSLV    = 3;
    localparam int TIMEOUT = 8;

    typedef struct {
        logic [XLEN-1:0] rdata;
        logic            err;
        int              lat;
    } exp_t;

    exp_t sb[$];
    logic clk   = 1'b0;
    logic arstn = 1'b0;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    int   t0       = 0;

    miriscv_apb_bridge_if #(.XLEN(XLEN), .NSLV(NSLV)) bus ();

    miriscv_apb_bridge #(
        .XLEN(XLEN), .NSLV(NSLV), .SEL_LSB(12), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i   (clk),
        .arstn_i (arstn),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idle_inputs();
        bus.data_req_i   = 1'b0;
        bus.data_we_i    = 1'b0;
        bus.data_be_i    = '0;
        bus.data_addr_i  = '0;
        bus.data_wdata_i = '0;
        bus.prdata_i     = '0;
        bus.pready_i     = '0;
        bus.pslverr_i    = '0;
    endtask

    task automatic apply_stimulus(input logic we, input logic [XLEN-1:0] addr,
                                  input logic [XLEN-1:0] wdata, input logic [3:0] be);
        bus.data_req_i   = 1'b1;
        bus.data_we_i    = we;
        bus.data_addr_i  = addr;
        bus.data_wdata_i = wdata;
        bus.data_be_i    = be;
    endtask

    task automatic push_exp(input logic [XLEN-1:0] rdata, input logic err, input int lat);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        e.lat   = lat;
        sb.push_back(e);
    endtask

    task automatic wait_rvalid(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.data_rvalid_o === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        arstn = 1'b0;
        apply_stimulus(1'b1, 32'h8000_0004, 32'h55, 4'hF);
        bus.pready_i = 3'b111;
        repeat (3) @(negedge clk);
        checks++; if (bus.psel_o !== 3'b000) begin failures++; $display("[TB] FAIL reset_psel: got %b expected %b", bus.psel_o, 3'b000); end
        checks++; if (bus.penable_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_penable: got %b expected 0", bus.penable_o); end
        checks++; if (bus.pwrite_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_pwrite: got %b expected 0", bus.pwrite_o); end
        checks++; if (bus.paddr_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_paddr: got %h expected 0", bus.paddr_o); end
        checks++; if (bus.pwdata_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_pwdata: got %h expected 0", bus.pwdata_o); end
        checks++; if (bus.pstrb_o !== 4'h0) begin failures++; $display("[TB] FAIL reset_pstrb: got %h expected 0", bus.pstrb_o); end
        checks++; if (bus.data_rvalid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_rvalid: got %b expected 0", bus.data_rvalid_o); end
        checks++; if (bus.data_rdata_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_rdata: got %h expected 0", bus.data_rdata_o); end
        checks++; if (bus.data_err_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b expected 0", bus.data_err_o); end
        idle_inputs();
        @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);
        checks++; if (bus.psel_o !== 3'b000) begin failures++; $display("[TB] FAIL reset_release_idle: got %b expected %b", bus.psel_o, 3'b000); end
    endtask

    task automatic test_write();
        exp_t e;
        bit   seen;
        @(negedge clk);
        t0 = cyc;
        apply_stimulus(1'b1, 32'h8000_0004, 32'h55, 4'hF);
        bus.pready_i = 3'b111;
        push_exp(32'h0, 1'b0, 3);
        @(negedge clk);
        bus.data_req_i = 1'b0;
        checks++; if (bus.psel_o !== 3'b001) begin failures++; $display("[TB] FAIL write_setup_psel: got %b expected %b", bus.psel_o, 3'b001); end
        checks++; if (bus.penable_o !== 1'b0) begin failures++; $display("[TB] FAIL write_setup_penable: got %b expected 0", bus.penable_o); end
        @(negedge clk);
        checks++; if (bus.penable_o !== 1'b1) begin failures++; $display("[TB] FAIL write_access_penable: got %b expected 1", bus.penable_o); end
        checks++; if (bus.pstrb_o !== 4'hF) begin failures++; $display("[TB] FAIL write_access_pstrb: got %h expected F", bus.pstrb_o); end
        checks++; if (bus.pwdata_o !== 32'h55) begin failures++; $display("[TB] FAIL write_access_pwdata: got %h expected 55", bus.pwdata_o); end
        checks++; if (bus.paddr_o !== 32'h8000_0004) begin failures++; $display("[TB] FAIL write_access_paddr: got %h expected 80000004", bus.paddr_o); end
        checks++; if (bus.pwrite_o !== 1'b1) begin failures++; $display("[TB] FAIL write_access_pwrite: got %b expected 1", bus.pwrite_o); end
        wait_rvalid(20, seen);
        e = sb.pop_front();
        checks++; if (!seen) begin failures++; $display("[TB] FAIL write_rvalid: got none expected pulse"); end
        checks++; if ((cyc - t0) !== e.lat) begin failures++; $display("[TB] FAIL write_latency: got %0d expected %0d", cyc - t0, e.lat); end
        checks++; if (bus.data_err_o !== e.err) begin failures++; $display("[TB] FAIL write_err: got %b expected %b", bus.data_err_o, e.err); end
        checks++; if (bus.data_rdata_o !== e.rdata) begin failures++; $display("[TB] FAIL write_rdata: got %h expected %h", bus.data_rdata_o, e.rdata); end
        checks++; if (bus.psel_o !== 3'b000) begin failures++; $display("[TB] FAIL write_resp_psel: got %b expected %b", bus.psel_o, 3'b000); end
        idle_inputs();
    endtask

    task automatic test_read_wait();
        exp_t e;
        bit   seen;
        @(negedge clk);
        t0 = cyc;
        apply_stimulus(1'b0, 32'h8000_1008, 32'h0, 4'hF);
        bus.pready_i  = 3'b101;
        bus.pslverr_i = 3'b101;
        bus.prdata_i  = {32'h0000_BBBB, 32'h0000_1234, 32'h0000_AAAA};
        push_exp(32'h0000_1234, 1'b0, 7);
        @(negedge clk);
        bus.data_req_i = 1'b0;
        checks++; if (bus.psel_o !== 3'b010) begin failures++; $display("[TB] FAIL read_setup_psel: got %b expected %b", bus.psel_o, 3'b010); end
        checks++; if (bus.penable_o !== 1'b0) begin failures++; $display("[TB] FAIL read_setup_penable: got %b expected 0", bus.penable_o); end
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            checks++; if (bus.psel_o !== 3'b010) begin failures++; $display("[TB] FAIL read_wait_psel: cycle %0d got %b expected %b", k, bus.psel_o, 3'b010); end
            checks++; if (bus.penable_o !== 1'b1) begin failures++; $display("[TB] FAIL read_wait_penable: cycle %0d got %b expected 1", k, bus.penable_o); end
            checks++; if (bus.paddr_o !== 32'h8000_1008) begin failures++; $display("[TB] FAIL read_wait_paddr: cycle %0d got %h expected 80001008", k, bus.paddr_o); end
            checks++; if (bus.pwrite_o !== 1'b0) begin failures++; $display("[TB] FAIL read_wait_pwrite: cycle %0d got %b expected 0", k, bus.pwrite_o); end
            checks++; if (bus.pstrb_o !== 4'h0) begin failures++; $display("[TB] FAIL read_wait_pstrb: cycle %0d got %h expected 0", k, bus.pstrb_o); end
            checks++; if (bus.data_rvalid_o !== 1'b0) begin failures++; $display("[TB] FAIL read_wait_rvalid: cycle %0d got %b expected 0", k, bus.data_rvalid_o); end
        end
        @(negedge clk);
        bus.pready_i = 3'b111;
        checks++; if (bus.penable_o !== 1'b1) begin failures++; $display("[TB] FAIL read_ready_penable: got %b expected 1", bus.penable_o); end
        wait_rvalid(20, seen);
        e = sb.pop_front();
        checks++; if (!seen) begin failures++; $display("[TB] FAIL read_rvalid: got none expected pulse"); end
        checks++; if ((cyc - t0) !== e.lat) begin failures++; $display("[TB] FAIL read_latency: got %0d expected %0d", cyc - t0, e.lat); end
        checks++; if (bus.data_rdata_o !== e.rdata) begin failures++; $display("[TB] FAIL read_rdata: got %h expected %h", bus.data_rdata_o, e.rdata); end
        checks++; if (bus.data_err_o !== e.err) begin failures++; $display("[TB] FAIL read_err_unselected_ignored: got %b expected %b", bus.data_err_o, e.err); end
        idle_inputs();
    endtask

    task automatic test_decode_error();
        exp_t e;
        @(negedge clk);
        t0 = cyc;
        apply_stimulus(1'b0, 32'h8000_3000, 32'h0, 4'hF);
        bus.pready_i = 3'b111;
        push_exp(32'h0, 1'b1, 1);
        @(negedge clk);
        bus.data_req_i = 1'b0;
        e = sb.pop_front();
        checks++; if (bus.data_rvalid_o !== 1'b1) begin failures++; $display("[TB] FAIL decode_rvalid: got %b expected 1 at cycle %0d", bus.data_rvalid_o, e.lat); end
        checks++; if (bus.psel_o !== 3'b000) begin failures++; $display("[TB] FAIL decode_psel: got %b expected %b", bus.psel_o, 3'b000); end
        checks++; if (bus.data_err_o !== e.err) begin failures++; $display("[TB] FAIL decode_err: got %b expected %b", bus.data_err_o, e.err); end
        checks++; if (bus.data_rdata_o !== e.rdata) begin failures++; $display("[TB] FAIL decode_rdata: got %h expected %h", bus.data_rdata_o, e.rdata); end
        @(negedge clk);
        checks++; if (bus.psel_o !== 3'b000) begin failures++; $display("[TB] FAIL decode_after_psel: got %b expected %b", bus.psel_o, 3'b000); end
        checks++; if (bus.data_err_o !== 1'b1) begin failures++; $display("[TB] FAIL decode_err_hold: got %b expected 1", bus.data_err_o); end
        idle_inputs();
    endtask

    task automatic test_slverr();
        exp_t e;
        bit   seen;
        @(negedge clk);
        t0 = cyc;
        apply_stimulus(1'b0, 32'h8000_2000, 32'h0, 4'hF);
        bus.pready_i  = 3'b111;
        bus.pslverr_i = 3'b100;
        bus.prdata_i  = {32'h0000_CAFE, 32'h0000_1111, 32'h0000_2222};
        push_exp(32'h0000_CAFE, 1'b1, 3);
        @(negedge clk);
        bus.data_req_i = 1'b0;
        checks++; if (bus.psel_o !== 3'b100) begin failures++; $display("[TB] FAIL slverr_setup_psel: got %b expected %b", bus.psel_o, 3'b100); end
        wait_rvalid(20, seen);
        e = sb.pop_front();
        checks++; if (!seen) begin failures++; $display("[TB] FAIL slverr_rvalid: got none expected pulse"); end
        checks++; if ((cyc - t0) !== e.lat) begin failures++; $display("[TB] FAIL slverr_latency: got %0d expected %0d", cyc - t0, e.lat); end
        checks++; if (bus.data_err_o !== e.err) begin failures++; $display("[TB] FAIL slverr_err: got %b expected %b", bus.data_err_o, e.err); end
        checks++; if (bus.data_rdata_o !== e.rdata) begin failures++; $display("[TB] FAIL slverr_rdata: got %h expected %h", bus.data_rdata_o, e.rdata); end
        idle_inputs();
    endtask

    task automatic test_timeout();
        exp_t e;
        bit   seen;
        @(negedge clk);
        t0 = cyc;
        apply_stimulus(1'b0, 32'h8000_0000, 32'h0, 4'hF);
        bus.pready_i = 3'b110;
        bus.prdata_i = {32'h0, 32'h0, 32'h0000_0099};
        push_exp(32'hDEAD_BEEF, 1'b1, 2 + TIMEOUT);
        @(negedge clk);
        bus.data_req_i = 1'b0;
        wait_rvalid(40, seen);
        e = sb.pop_front();
        checks++; if (!seen) begin failures++; $display("[TB] FAIL timeout_rvalid: got none expected pulse"); end
        checks++; if ((cyc - t0) !== e.lat) begin failures++; $display("[TB] FAIL timeout_latency: got %0d expected %0d", cyc - t0, e.lat); end
        checks++; if (bus.data_err_o !== e.err) begin failures++; $display("[TB] FAIL timeout_err: got %b expected %b", bus.data_err_o, e.err); end
        checks++; if (bus.data_rdata_o !== e.rdata) begin failures++; $display("[TB] FAIL timeout_rdata: got %h expected %h", bus.data_rdata_o, e.rdata); end
        checks++; if (bus.psel_o !== 3'b000) begin failures++; $display("[TB] FAIL timeout_psel: got %b expected %b", bus.psel_o, 3'b000); end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit   seen;
        int   t1;
        @(negedge clk);
        t0 = cyc;
        apply_stimulus(1'b1, 32'h8000_0010, 32'h0000_A5A5, 4'h3);
        bus.pready_i = 3'b111;
        bus.prdata_i = {32'h0, 32'h0000_0077, 32'h0};
        push_exp(32'h0, 1'b0, 3);
        wait_rvalid(20, seen);
        e = sb.pop_front();
        checks++; if (!seen) begin failures++; $display("[TB] FAIL b2b_first_rvalid: got none expected pulse"); end
        checks++; if ((cyc - t0) !== e.lat) begin failures++; $display("[TB] FAIL b2b_first_latency: got %0d expected %0d", cyc - t0, e.lat); end
        checks++; if (bus.data_rdata_o !== e.rdata) begin failures++; $display("[TB] FAIL b2b_first_rdata: got %h expected %h", bus.data_rdata_o, e.rdata); end
        t1 = cyc;
        apply_stimulus(1'b0, 32'h8000_1004, 32'h0, 4'hF);
        push_exp(32'h0000_0077, 1'b0, 3);
        @(negedge clk);
        bus.data_req_i = 1'b0;
        checks++; if (bus.psel_o !== 3'b010) begin failures++; $display("[TB] FAIL b2b_second_setup_psel: got %b expected %b", bus.psel_o, 3'b010); end
        checks++; if (bus.penable_o !== 1'b0) begin failures++; $display("[TB] FAIL b2b_second_setup_penable: got %b expected 0", bus.penable_o); end
        checks++; if (bus.pwrite_o !== 1'b0) begin failures++; $display("[TB] FAIL b2b_second_pwrite: got %b expected 0", bus.pwrite_o); end
        wait_rvalid(20, seen);
        e = sb.pop_front();
        checks++; if (!seen) begin failures++; $display("[TB] FAIL b2b_second_rvalid: got none expected pulse"); end
        checks++; if ((cyc - t1) !== e.lat) begin failures++; $display("[TB] FAIL b2b_second_latency: got %0d expected %0d", cyc - t1, e.lat); end
        checks++; if (bus.data_rdata_o !== e.rdata) begin failures++; $display("[TB] FAIL b2b_second_rdata: got %h expected %h", bus.data_rdata_o, e.rdata); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        apply_stimulus(1'b0, 32'h8000_0020, 32'h0, 4'hF);
        bus.pready_i = 3'b000;
        @(negedge clk);
        bus.data_req_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.penable_o !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_in_access: got %b expected 1", bus.penable_o); end
        @(negedge clk);
        arstn = 1'b0;
        @(negedge clk);
        checks++; if (bus.psel_o !== 3'b000) begin failures++; $display("[TB] FAIL rstmid_psel: got %b expected %b", bus.psel_o, 3'b000); end
        checks++; if (bus.penable_o !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_penable: got %b expected 0", bus.penable_o); end
        checks++; if (bus.paddr_o !== 32'h0) begin failures++; $display("[TB] FAIL rstmid_paddr: got %h expected 0", bus.paddr_o); end
        checks++; if (bus.pstrb_o !== 4'h0) begin failures++; $display("[TB] FAIL rstmid_pstrb: got %h expected 0", bus.pstrb_o); end
        checks++; if (bus.data_rdata_o !== 32'h0) begin failures++; $display("[TB] FAIL rstmid_rdata: got %h expected 0", bus.data_rdata_o); end
        checks++; if (bus.data_err_o !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_err: got %b expected 0", bus.data_err_o); end
        checks++; if (bus.data_rvalid_o !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_rvalid: got %b expected 0", bus.data_rvalid_o); end
        bus.pready_i = 3'b111;
        @(negedge clk);
        arstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (bus.data_rvalid_o !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_no_rvalid: cycle %0d got %b expected 0", k, bus.data_rvalid_o); end
            checks++; if (bus.psel_o !== 3'b000) begin failures++; $display("[TB] FAIL rstmid_no_resume: cycle %0d got %b expected %b", k, bus.psel_o, 3'b000); end
        end
        idle_inputs();
    endtask

    initial begin
        $display("[TB] miriscv_apb_bridge bench start");
        test_reset();
        test_write();
        test_read_wait();
        test_decode_error();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
